// File: rtl/vram_mux_arbiter.sv
// vram_mux_arbiter
//   Shares one video RAM between the video scanner (port 0) and the CPU (port 1).
//   Every access is a fixed two-cycle ADDR/DATA sequence. Video has priority, but a CPU
//   request that has waited STARVE_LIMIT cycles outranks a pending video request.
//   Drives the select/enable of the ls157 address-mux chain and the VRAM write strobe.
//
// Ports
//   clk         in   system clock, rising edge
//   n_reset     in   asynchronous active-low reset
//   vid_req     in   1-cycle pulse: video fetch needed
//   cpu_req     in   level: CPU access pending, held until cpu_ack
//   cpu_wr      in   sampled at CPU grant: 1 = write, 0 = read
//   mux_s       out  ls157 select: 0 = video address, 1 = CPU address
//   mux_n_e     out  ls157 enable, active low
//   ram_n_we    out  VRAM write strobe, active low
//   vid_latch   out  1-cycle pulse: video data valid
//   cpu_ack     out  1-cycle pulse: CPU access done
//   n_cpu_wait  out  active low CPU stall
//   vid_miss    out  1-cycle pulse: a video request was dropped

module vram_mux_arbiter #(
    parameter int unsigned STARVE_LIMIT = 6,
    parameter int unsigned CNT_W        = 3
) (
    input  logic clk,
    input  logic n_reset,
    input  logic vid_req,
    input  logic cpu_req,
    input  logic cpu_wr,
    output logic mux_s,
    output logic mux_n_e,
    output logic ram_n_we,
    output logic vid_latch,
    output logic cpu_ack,
    output logic n_cpu_wait,
    output logic vid_miss
);

    typedef enum logic [2:0] {
        StIdle,
        StVAddr,
        StVData,
        StCAddr,
        StCData
    } state_e;

    localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CntMax      = '1;

    state_e           state_q, state_d;
    logic             vid_pend_q, vid_pend_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             wr_q, wr_d;
    logic             mux_s_q, mux_s_d;
    logic             mux_n_e_q, mux_n_e_d;
    logic             ram_n_we_q, ram_n_we_d;
    logic             vid_latch_q, vid_latch_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             vid_miss_q, vid_miss_d;

    logic   vid_want;
    logic   cpu_want;
    logic   cpu_starved;
    logic   enter_vaddr;
    logic   enter_caddr;
    logic   cpu_waiting;
    state_e grant;

    // Next state and grant decision
    always_comb begin
        vid_want    = vid_pend_q | vid_req;
        // The ack in C_DATA consumes the current request; the CPU must re-raise it.
        cpu_want    = cpu_req && (state_q != StCData);
        cpu_starved = starve_cnt_q >= StarveLimit;

        grant = StIdle;
        if (vid_want && cpu_want) begin
            grant = cpu_starved ? StCAddr : StVAddr;
        end else if (vid_want) begin
            grant = StVAddr;
        end else if (cpu_want) begin
            grant = StCAddr;
        end

        state_d = StIdle;
        unique case (state_q)
            StIdle:  state_d = grant;
            StVAddr: state_d = StVData;
            StVData: state_d = grant;
            StCAddr: state_d = StCData;
            StCData: state_d = grant;
            default: state_d = StIdle;
        endcase
    end

    // Bookkeeping: pending video, starvation counter, latched write flag
    always_comb begin
        enter_vaddr = (state_d == StVAddr) && (state_q != StVAddr);
        enter_caddr = (state_d == StCAddr) && (state_q != StCAddr);
        cpu_waiting = cpu_req && (state_q != StCAddr) && (state_q != StCData);

        // A request arriving in the same cycle a pending one is served stays pending.
        vid_pend_d = enter_vaddr ? (vid_pend_q & vid_req) : (vid_pend_q | vid_req);
        vid_miss_d = vid_req & vid_pend_q & ~enter_vaddr;

        starve_cnt_d = starve_cnt_q;
        if (!cpu_req || enter_caddr) begin
            starve_cnt_d = '0;
        end else if (cpu_waiting && (starve_cnt_q != CntMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        wr_d = enter_caddr ? cpu_wr : wr_q;
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        mux_s_d     = mux_s_q;
        mux_n_e_d   = 1'b1;
        ram_n_we_d  = 1'b1;
        vid_latch_d = 1'b0;
        cpu_ack_d   = 1'b0;
        unique case (state_d)
            StIdle: begin
            end
            StVAddr: begin
                mux_s_d   = 1'b0;
                mux_n_e_d = 1'b0;
            end
            StVData: begin
                mux_s_d     = 1'b0;
                mux_n_e_d   = 1'b0;
                vid_latch_d = 1'b1;
            end
            StCAddr: begin
                mux_s_d   = 1'b1;
                mux_n_e_d = 1'b0;
            end
            StCData: begin
                mux_s_d    = 1'b1;
                mux_n_e_d  = 1'b0;
                ram_n_we_d = ~wr_d;
                cpu_ack_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            vid_pend_q   <= 1'b0;
            starve_cnt_q <= '0;
            wr_q         <= 1'b0;
            mux_s_q      <= 1'b0;
            mux_n_e_q    <= 1'b1;
            ram_n_we_q   <= 1'b1;
            vid_latch_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_miss_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vid_pend_q   <= vid_pend_d;
            starve_cnt_q <= starve_cnt_d;
            wr_q         <= wr_d;
            mux_s_q      <= mux_s_d;
            mux_n_e_q    <= mux_n_e_d;
            ram_n_we_q   <= ram_n_we_d;
            vid_latch_q  <= vid_latch_d;
            cpu_ack_q    <= cpu_ack_d;
            vid_miss_q   <= vid_miss_d;
        end
    end

    assign mux_s      = mux_s_q;
    assign mux_n_e    = mux_n_e_q;
    assign ram_n_we   = ram_n_we_q;
    assign vid_latch  = vid_latch_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_miss   = vid_miss_q;
    assign n_cpu_wait = !(cpu_req && !cpu_ack_q);

endmodule

// File: tb/tb_vram_mux_arbiter.sv
// tb_vram_mux_arbiter
//   Directed stimulus; expected vid_latch / cpu_ack / vid_miss pulses (kind, cycle, write
//   strobe) are queued when stimulus is issued and popped by an independent monitor.

module tb_vram_mux_arbiter;

    logic clk;
    logic n_reset;
    logic vid_req;
    logic cpu_req;
    logic cpu_wr;
    logic mux_s;
    logic mux_n_e;
    logic ram_n_we;
    logic vid_latch;
    logic cpu_ack;
    logic n_cpu_wait;
    logic vid_miss;

    vram_mux_arbiter #(
        .STARVE_LIMIT(6),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .vid_req   (vid_req),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .mux_s     (mux_s),
        .mux_n_e   (mux_n_e),
        .ram_n_we  (ram_n_we),
        .vid_latch (vid_latch),
        .cpu_ack   (cpu_ack),
        .n_cpu_wait(n_cpu_wait),
        .vid_miss  (vid_miss)
    );

    localparam logic [1:0] EvLatch = 2'd0;
    localparam logic [1:0] EvAck   = 2'd1;
    localparam logic [1:0] EvMiss  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        int         cyc;
        logic       we;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input int c, input logic we);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.we   = we;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input logic [1:0] kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.cyc !== cyc || (kind == EvAck && e.we !== ram_n_we)) begin
                failed++;
                $display("FAIL event: got kind %0d cycle %0d we %0b, expected kind %0d cycle %0d we %0b",
                         kind, cyc, ram_n_we, e.kind, e.cyc, e.we);
            end
        end
    endtask

    // Monitor: fixed order latch, ack, miss within one cycle
    always @(negedge clk) begin
        if (vid_latch === 1'b1) mon_ev(EvLatch);
        if (cpu_ack === 1'b1) mon_ev(EvAck);
        if (vid_miss === 1'b1) mon_ev(EvMiss);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vid_req = 1'b0;
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int base;
        n_reset = 1'b0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mux_s", 32'(mux_s), 0);
        chk("rst_mux_n_e", 32'(mux_n_e), 1);
        chk("rst_ram_n_we", 32'(ram_n_we), 1);
        chk("rst_vid_latch", 32'(vid_latch), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_vid_miss", 32'(vid_miss), 0);
        chk("rst_n_cpu_wait", 32'(n_cpu_wait), 1);
        tick();
        n_reset = 1'b1;
        idle(3);

        // Idle video fetch
        base = cyc;
        push_ev(EvLatch, base + 2, 1'b1);
        vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        chk("v_c1_mux_s", 32'(mux_s), 0);
        chk("v_c1_mux_n_e", 32'(mux_n_e), 0);
        tick();
        @(negedge clk);
        chk("v_c2_mux_s", 32'(mux_s), 0);
        chk("v_c2_mux_n_e", 32'(mux_n_e), 0);
        tick();
        @(negedge clk);
        chk("v_c3_mux_n_e", 32'(mux_n_e), 1);
        idle(3);

        // Idle CPU write
        base = cyc;
        push_ev(EvAck, base + 2, 1'b0);
        cpu_req = 1'b1;
        cpu_wr  = 1'b1;
        @(negedge clk);
        chk("cw_c0_wait", 32'(n_cpu_wait), 0);
        tick();
        @(negedge clk);
        chk("cw_c1_wait", 32'(n_cpu_wait), 0);
        chk("cw_c1_mux_s", 32'(mux_s), 1);
        chk("cw_c1_mux_n_e", 32'(mux_n_e), 0);
        chk("cw_c1_ram_n_we", 32'(ram_n_we), 1);
        tick();
        @(negedge clk);
        chk("cw_c2_mux_s", 32'(mux_s), 1);
        chk("cw_c2_wait", 32'(n_cpu_wait), 1);
        tick();
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        @(negedge clk);
        chk("cw_c3_mux_n_e", 32'(mux_n_e), 1);
        chk("cw_c3_mux_s_hold", 32'(mux_s), 1);
        chk("cw_c3_ram_n_we", 32'(ram_n_we), 1);
        idle(3);

        // Simultaneous requests, no starvation: video then CPU read back-to-back
        base = cyc;
        push_ev(EvLatch, base + 2, 1'b1);
        push_ev(EvAck, base + 4, 1'b1);
        for (int k = 0; k <= 5; k++) begin
            vid_req = (k == 0);
            cpu_req = (k <= 4);
            cpu_wr  = 1'b0;
            @(negedge clk);
            if (k == 1) chk("both_c1_mux_s", 32'(mux_s), 0);
            if (k == 3) chk("both_c3_mux_s", 32'(mux_s), 1);
            if (k == 3) chk("both_c3_mux_n_e", 32'(mux_n_e), 0);
            if (k == 4) chk("both_c4_ram_n_we", 32'(ram_n_we), 1);
            tick();
        end
        idle(3);

        // Periodic video with CPU held: CPU wins once the counter reaches the limit
        base = cyc;
        push_ev(EvLatch, base + 2, 1'b1);
        push_ev(EvLatch, base + 4, 1'b1);
        push_ev(EvLatch, base + 6, 1'b1);
        push_ev(EvAck, base + 8, 1'b0);
        push_ev(EvLatch, base + 10, 1'b1);
        push_ev(EvLatch, base + 12, 1'b1);
        for (int k = 0; k <= 13; k++) begin
            vid_req = (k <= 8) && (k % 2 == 0);
            cpu_req = (k <= 8);
            cpu_wr  = 1'b1;
            @(negedge clk);
            if (k == 6) chk("starve_c6_mux_s", 32'(mux_s), 0);
            if (k == 7) chk("starve_c7_mux_s", 32'(mux_s), 1);
            if (k == 7) chk("starve_c7_wait", 32'(n_cpu_wait), 0);
            if (k == 9) chk("starve_c9_mux_s", 32'(mux_s), 0);
            if (k == 13) chk("starve_c13_mux_n_e", 32'(mux_n_e), 1);
            tick();
        end
        idle(3);

        // Video requests during a CPU read: pending, back-to-back, then one dropped
        base = cyc;
        push_ev(EvAck, base + 2, 1'b1);
        push_ev(EvLatch, base + 4, 1'b1);
        push_ev(EvMiss, base + 4, 1'b1);
        push_ev(EvLatch, base + 6, 1'b1);
        for (int k = 0; k <= 7; k++) begin
            cpu_req = (k <= 2);
            cpu_wr  = 1'b0;
            vid_req = (k >= 1) && (k <= 3);
            @(negedge clk);
            if (k == 3) chk("pend_c3_mux_s", 32'(mux_s), 0);
            if (k == 5) chk("pend_c5_mux_n_e", 32'(mux_n_e), 0);
            if (k == 7) chk("pend_c7_mux_n_e", 32'(mux_n_e), 1);
            tick();
        end
        idle(3);

        // Reset in the middle of a CPU write strobe
        base = cyc;
        push_ev(EvAck, base + 2, 1'b0);
        cpu_req = 1'b1;
        cpu_wr  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rstmid_pre_ram_n_we", 32'(ram_n_we), 0);
        #2;
        n_reset = 1'b0;
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        #1;
        chk("rstmid_ram_n_we", 32'(ram_n_we), 1);
        chk("rstmid_mux_n_e", 32'(mux_n_e), 1);
        chk("rstmid_mux_s", 32'(mux_s), 0);
        chk("rstmid_cpu_ack", 32'(cpu_ack), 0);
        tick();
        n_reset = 1'b1;
        @(negedge clk);
        chk("rstmid_idle_mux_n_e", 32'(mux_n_e), 1);
        tick();
        @(negedge clk);
        chk("rstmid_idle2_mux_n_e", 32'(mux_n_e), 1);
        chk("rstmid_idle2_ram_n_we", 32'(ram_n_we), 1);
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
